axi4_lite_bridge_regs: RTL
==========================

// Module: axi4_lite_bridge_regs
// PURPOSE
//  AXI4-Lite slave register file on the AXI side of the UART-AXI4 bridge; the first target the bridge's master reaches.
//  Exposes bridge status counters as read-only registers and holds writable control/scratch registers.
//  Drives the bridge statistics-reset pulse and captures bridge error codes.
//  Single clock domain, synchronous active-low reset.
// PARAMETERS
//  BASE_ADDR     32'h0000_1000  decoded region base; 4 KB window, offset = addr[11:0]
//  VERSION_WORD  32'h0001_0000  value returned at VERSION offset
//  SCRATCH_RST   32'h0000_0000  reset value of SCRATCH
// PORTS
//  clk                    in   1   system clock
//  rst                    in   1   synchronous, active-low reset (0 = reset)
//  axi                    if   -   axi4_lite_if.slave; 32-bit addr/data, 4-bit wstrb, 2-bit resp
//  bridge_busy            in   1   bridge busy status
//  bridge_error_code      in   8   bridge current error code (0 = none)
//  tx_transaction_count   in   16  bridge write-transaction counter
//  rx_transaction_count   in   16  bridge read-transaction counter
//  fifo_status_flags      in   8   bridge FIFO flags
//  reset_statistics       out  1   1-cycle pulse to clear bridge counters
//  ctrl_enable            out  1   CONTROL[1], general enable to system
// BEHAVIOUR
//  Map (offset, word-aligned; addr[1:0] ignored):
//   0x00 CONTROL  RW  [0] STAT_CLR (self-clearing, reads 0), [1] ENABLE; other bits read 0
//   0x04 STATUS   RO  {15'b0, bridge_busy, fifo_status_flags, bridge_error_code}
//   0x08 COUNTS   RO  {rx_transaction_count, tx_transaction_count}
//   0x0C ERRCAP   W1C [7:0] first nonzero error code captured, [8] sticky valid, [31:16] capture count (saturating at 16'hFFFF)
//   0x10 SCRATCH  RW  32-bit, wstrb honoured per byte
//   0x14 VERSION  RO  VERSION_WORD
//  Responses: hit RW/W1C -> OKAY 2'b00; write to RO -> SLVERR 2'b10, no state change;
//   addr outside [BASE_ADDR, BASE_ADDR+0xFFF] or unmapped offset -> DECERR 2'b11, rdata 0.
//  Reset (rst=0): awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0,
//   CONTROL=0, ERRCAP=0, SCRATCH=SCRATCH_RST, reset_statistics=0, ctrl_enable=0.
//  Write FSM W_IDLE -> W_RESP: AW and W captured independently (either order / same cycle) into holding regs;
//   awready=!aw_held&&!bvalid, wready=!w_held&&!bvalid; ready deasserted in reset.
//   When both held: register updated that cycle, bvalid=1 next cycle; holds cleared.
//   W_RESP: bvalid and bresp stable until bready; return to W_IDLE on bvalid&&bready.
//  Read FSM R_IDLE -> R_RESP: arready=!rvalid; on arvalid&&arready rdata/rresp registered, rvalid=1 next cycle;
//   rdata/rresp stable while rvalid&&!rready; clear on handshake. Latency 1 cycle AR->R.
//  Same-cycle read and write of same register: read returns pre-write value.
//  STAT_CLR: writing 1 to CONTROL[0] with wstrb[0]=1 asserts reset_statistics for exactly 1 cycle after write commit.
//  ERRCAP: when bridge_error_code!=0 and ERRCAP[8]=0, capture code and set [8]; count increments every cycle
//   entry into nonzero (0->nonzero edge of code), saturating. W1C bit [8] clears [8] and [7:0];
//   W1C on [16] clears count. Capture event and W1C in same cycle: capture wins (sticky remains set).
//  Reset mid-transaction: all channel state discarded; no pending B/R response after rst returns high.
// STRUCTURE
//  Shared package (axiuart_regs_pkg): offset localparams, axi_resp_t enum (OKAY/SLVERR/DECERR), ctrl_reg_t packed struct.
//  Single sub-module natural: axi4_lite_slave_if_fsm (AW/W/B and AR/R handshakes -> wr_en/wr_addr/wr_data/wstrb,
//   rd_en/rd_addr, with resp input); register decode/storage stays in this module.
// TESTING
//  Write SCRATCH 0xDEADBEEF wstrb=4'hF, then wstrb=4'h2 data 0x0000_5500 -> read returns 0xDEAD55EF, OKAY.
//  W before AW by 3 cycles, bready held low 5 cycles -> single B, bresp=OKAY, bvalid stable until bready.
//  Write CONTROL=0x3 -> reset_statistics high exactly 1 cycle; read CONTROL returns 0x2; ctrl_enable=1.
//  Write COUNTS -> SLVERR, COUNTS unchanged; read BASE_ADDR+0x40 -> DECERR, rdata 0.
//  bridge_error_code 0x00->0x05->0x00->0x07 -> ERRCAP reads 0x0002_0105; write 0x0001_0100 -> reads 0.
//  Assert rst low with rvalid pending and rready=0 -> after release rvalid=0, arready re-asserted next cycle.

Source files
------------

// File: rtl/axiuart_regs_pkg.sv
// Shared types and register map for the UART-AXI4 bridge register file.
package axiuart_regs_pkg;

  localparam logic [11:0] OFF_CONTROL = 12'h000;
  localparam logic [11:0] OFF_STATUS  = 12'h004;
  localparam logic [11:0] OFF_COUNTS  = 12'h008;
  localparam logic [11:0] OFF_ERRCAP  = 12'h00C;
  localparam logic [11:0] OFF_SCRATCH = 12'h010;
  localparam logic [11:0] OFF_VERSION = 12'h014;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef struct packed {
    logic [29:0] rsvd;
    logic        enable;
    logic        stat_clr;
  } ctrl_reg_t;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  typedef enum logic [2:0] {
    REG_CONTROL, REG_STATUS, REG_COUNTS, REG_ERRCAP, REG_SCRATCH, REG_VERSION, REG_NONE
  } reg_sel_t;

  // Anything outside the 4 KB window, or an unmapped word inside it, selects REG_NONE.
  function automatic reg_sel_t decode_addr(input logic [31:0] addr, input logic [31:0] base);
    logic [11:0] off;
    off = addr[11:0] & 12'hFFC;
    if ((addr & 32'hFFFF_F000) != (base & 32'hFFFF_F000)) return REG_NONE;
    case (off)
      OFF_CONTROL: return REG_CONTROL;
      OFF_STATUS:  return REG_STATUS;
      OFF_COUNTS:  return REG_COUNTS;
      OFF_ERRCAP:  return REG_ERRCAP;
      OFF_SCRATCH: return REG_SCRATCH;
      OFF_VERSION: return REG_VERSION;
      default:     return REG_NONE;
    endcase
  endfunction

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle: 32-bit address/data, byte strobes, 2-bit responses.
interface axi4_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_slave_if_fsm.sv
// AXI4-Lite slave handshake engine: turns AW/W/B and AR/R traffic into single-cycle
// register write and read strobes.
module axi4_lite_slave_if_fsm
  import axiuart_regs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  axi4_lite_if.slave        axi,
  output logic              o_wr_en,
  output logic [31:0]       o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic [3:0]        o_wr_strb,
  input  axi_resp_t         i_wr_resp,
  output logic              o_rd_en,
  output logic [31:0]       o_rd_addr,
  input  logic [31:0]       i_rd_data,
  input  axi_resp_t         i_rd_resp
);

  w_state_t    r_w_state, w_w_state_nxt;
  r_state_t    r_r_state, w_r_state_nxt;
  logic        r_active;
  logic        r_aw_held, r_w_held;
  logic [31:0] r_awaddr, r_wdata;
  logic [3:0]  r_wstrb;
  axi_resp_t   r_bresp, r_rresp;
  logic [31:0] r_rdata;
  logic        w_aw_hs, w_w_hs, w_ar_hs, w_commit;

  // r_active keeps every ready low until the first cycle after reset is released.
  assign axi.awready = r_active && !r_aw_held && (r_w_state == W_IDLE);
  assign axi.wready  = r_active && !r_w_held  && (r_w_state == W_IDLE);
  assign axi.arready = r_active && (r_r_state == R_IDLE);
  assign axi.bvalid  = (r_w_state == W_RESP);
  assign axi.bresp   = r_bresp;
  assign axi.rvalid  = (r_r_state == R_RESP);
  assign axi.rresp   = r_rresp;
  assign axi.rdata   = r_rdata;

  assign w_aw_hs  = axi.awvalid && axi.awready;
  assign w_w_hs   = axi.wvalid  && axi.wready;
  assign w_ar_hs  = axi.arvalid && axi.arready;
  assign w_commit = r_aw_held && r_w_held;

  assign o_wr_en   = w_commit;
  assign o_wr_addr = r_awaddr;
  assign o_wr_data = r_wdata;
  assign o_wr_strb = r_wstrb;
  assign o_rd_en   = w_ar_hs;
  assign o_rd_addr = axi.araddr;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_w_state_nxt = r_w_state;
    w_r_state_nxt = r_r_state;
    case (r_w_state)
      W_IDLE:  if (w_commit)   w_w_state_nxt = W_RESP;
      W_RESP:  if (axi.bready) w_w_state_nxt = W_IDLE;
      default: w_w_state_nxt = W_IDLE;
    endcase
    case (r_r_state)
      R_IDLE:  if (w_ar_hs)    w_r_state_nxt = R_RESP;
      R_RESP:  if (axi.rready) w_r_state_nxt = R_IDLE;
      default: w_r_state_nxt = R_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_w_state <= W_IDLE;
      r_r_state <= R_IDLE;
    end else begin
      r_w_state <= w_w_state_nxt;
      r_r_state <= w_r_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_active  <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_active <= 1'b1;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= axi.awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= axi.wdata;
        r_wstrb  <= axi.wstrb;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bresp   <= i_wr_resp;
      end
      if (w_ar_hs) begin
        r_rdata <= i_rd_data;
        r_rresp <= i_rd_resp;
      end else if (axi.rvalid && axi.rready) begin
        r_rdata <= '0;
        r_rresp <= RESP_OKAY;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_bridge_regs.sv
// Bridge register file: status/counter views, CONTROL/SCRATCH storage, error-code capture
// and the statistics-reset pulse, behind an AXI4-Lite slave port.
module axi4_lite_bridge_regs
  import axiuart_regs_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter logic [31:0] VERSION_WORD = 32'h0001_0000,
  parameter logic [31:0] SCRATCH_RST  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  axi4_lite_if.slave  axi,
  input  logic        bridge_busy,
  input  logic [7:0]  bridge_error_code,
  input  logic [15:0] tx_transaction_count,
  input  logic [15:0] rx_transaction_count,
  input  logic [7:0]  fifo_status_flags,
  output logic        reset_statistics,
  output logic        ctrl_enable
);

  logic        w_wr_en, w_rd_en;
  logic [31:0] w_wr_addr, w_wr_data, w_rd_addr, w_rd_data;
  logic [3:0]  w_wr_strb;
  axi_resp_t   w_wr_resp, w_rd_resp;
  reg_sel_t    w_wr_sel, w_rd_sel;
  ctrl_reg_t   w_ctrl_view;

  logic        r_ctrl_enable, r_reset_statistics;
  logic [31:0] r_scratch;
  logic [7:0]  r_err_code, r_prev_code;
  logic        r_err_valid;
  logic [15:0] r_err_count;
  logic        w_wr_ctrl, w_wr_errcap, w_wr_scratch;
  logic        w_err_edge, w_capture, w_clr_valid, w_clr_count;

  axi4_lite_slave_if_fsm u_if_fsm (
    .clk       (clk),
    .rst       (rst),
    .axi       (axi),
    .o_wr_en   (w_wr_en),
    .o_wr_addr (w_wr_addr),
    .o_wr_data (w_wr_data),
    .o_wr_strb (w_wr_strb),
    .i_wr_resp (w_wr_resp),
    .o_rd_en   (w_rd_en),
    .o_rd_addr (w_rd_addr),
    .i_rd_data (w_rd_data),
    .i_rd_resp (w_rd_resp)
  );

  assign w_wr_sel    = decode_addr(w_wr_addr, BASE_ADDR);
  assign w_rd_sel    = decode_addr(w_rd_addr, BASE_ADDR);
  assign w_ctrl_view = '{rsvd: '0, enable: r_ctrl_enable, stat_clr: 1'b0};

  always_comb begin
    w_wr_resp = RESP_DECERR;
    case (w_wr_sel)
      REG_CONTROL, REG_ERRCAP, REG_SCRATCH: w_wr_resp = RESP_OKAY;
      REG_STATUS, REG_COUNTS, REG_VERSION:  w_wr_resp = RESP_SLVERR;
      default:                              w_wr_resp = RESP_DECERR;
    endcase
  end

  // Read mux sees pre-write values, so a read racing a write returns the old contents.
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    if (w_rd_en) begin
      case (w_rd_sel)
        REG_CONTROL: w_rd_data = w_ctrl_view;
        REG_STATUS:  w_rd_data = {15'b0, bridge_busy, fifo_status_flags, bridge_error_code};
        REG_COUNTS:  w_rd_data = {rx_transaction_count, tx_transaction_count};
        REG_ERRCAP:  w_rd_data = {r_err_count, 7'b0, r_err_valid, r_err_code};
        REG_SCRATCH: w_rd_data = r_scratch;
        REG_VERSION: w_rd_data = VERSION_WORD;
        default:     w_rd_resp = RESP_DECERR;
      endcase
    end
  end

  assign w_wr_ctrl    = w_wr_en && (w_wr_sel == REG_CONTROL);
  assign w_wr_errcap  = w_wr_en && (w_wr_sel == REG_ERRCAP);
  assign w_wr_scratch = w_wr_en && (w_wr_sel == REG_SCRATCH);
  assign w_err_edge   = (r_prev_code == 8'h00) && (bridge_error_code != 8'h00);
  assign w_capture    = (bridge_error_code != 8'h00) && !r_err_valid;
  assign w_clr_valid  = w_wr_errcap && w_wr_strb[1] && w_wr_data[8];
  assign w_clr_count  = w_wr_errcap && w_wr_strb[2] && w_wr_data[16];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ctrl_enable      <= 1'b0;
      r_reset_statistics <= 1'b0;
      r_scratch          <= SCRATCH_RST;
      r_prev_code        <= 8'h00;
      r_err_code         <= 8'h00;
      r_err_valid        <= 1'b0;
      r_err_count        <= 16'h0000;
    end else begin
      r_reset_statistics <= w_wr_ctrl && w_wr_strb[0] && w_wr_data[0];
      if (w_wr_ctrl && w_wr_strb[0]) r_ctrl_enable <= w_wr_data[1];
      if (w_wr_scratch) r_scratch <= apply_wstrb(r_scratch, w_wr_data, w_wr_strb);
      r_prev_code <= bridge_error_code;
      // A capture in the same cycle as a W1C wins, leaving the sticky bit set.
      if (w_capture) begin
        r_err_code  <= bridge_error_code;
        r_err_valid <= 1'b1;
      end else if (w_clr_valid) begin
        r_err_code  <= 8'h00;
        r_err_valid <= 1'b0;
      end
      if (w_clr_count)                               r_err_count <= w_err_edge ? 16'h0001 : 16'h0000;
      else if (w_err_edge && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'h0001;
    end
  end

  assign reset_statistics = r_reset_statistics;
  assign ctrl_enable      = r_ctrl_enable;

endmodule
